// File: rtl/sdram_pkg.sv
// sdram_pkg: byte-lane encodings, write-entry layout and issue FSM states shared by the SDRAM download writer
package sdram_pkg;
  localparam logic [1:0] DS_HI = 2'b10;
  localparam logic [1:0] DS_LO = 2'b01;
  localparam logic [1:0] DS_W = 2'b11;
  typedef struct packed {
    logic [23:1] a;
    logic [1:0] ds;
    logic [15:0] d;
  } sdram_wr_t;
  typedef enum logic [1:0] {SYNC, IDLE, BUSY} wr_state_t;
endpackage

// File: rtl/sdram_dl_writer_if.sv
// sdram_dl_writer_if: toggle req/ack write port between the download writer and one SDRAM controller port
interface sdram_dl_writer_if;
  logic req;
  logic ack;
  logic we;
  logic [23:1] a;
  logic [1:0] ds;
  logic [15:0] d;
  modport master (output req, we, a, ds, d, input ack);
  modport slave (input req, we, a, ds, d, output ack);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers; a push while full is taken only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/sdram_dl_writer.sv
// sdram_dl_writer: packs loader bytes into 16-bit SDRAM writes, buffers them and issues them over a toggle handshake
module sdram_dl_writer
  import sdram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic init_n,
  input  logic dl_wr,
  input  logic [23:0] dl_addr,
  input  logic [7:0] dl_data,
  input  logic dl_end,
  output logic dl_wait,
  output logic dl_idle,
  output logic dl_overrun,
  sdram_dl_writer_if.master port
);
  wr_state_t state, state_n;
  sdram_wr_t push_w, head;
  logic push, pop, load, req_n, full, empty;
  logic pend_v, flush_req, even, same, drop, flush_go;
  logic [23:1] pend_a;
  logic [7:0] pend_d;
  sync_fifo #(.WIDTH($bits(sdram_wr_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(init_n), .push(push), .pop(pop), .wdata(push_w),
    .rdata(head), .full(full), .empty(empty)
  );
  assign port.we = 1'b1;
  assign dl_wait = full;
  assign dl_idle = state == IDLE && empty && !pend_v && !flush_req;
  always_comb begin
    even = !dl_addr[0];
    same = pend_v && pend_a == dl_addr[23:1];
    flush_go = flush_req && !dl_wr && !full;
    drop = dl_wr && !even && pend_v && !same;
    push = dl_wr ? (even ? pend_v : !drop) : flush_go && pend_v;
    push_w = (dl_wr && !even)
      ? {same ? pend_a : dl_addr[23:1], same ? DS_W : DS_LO, same ? pend_d : 8'h00, dl_data}
      : {pend_a, DS_HI, pend_d, 8'h00};
  end
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      pend_v <= 1'b0;
      pend_a <= '0;
      pend_d <= '0;
      flush_req <= 1'b0;
      dl_overrun <= 1'b0;
    end else begin
      if (dl_wr && even) {pend_v, pend_a, pend_d} <= {1'b1, dl_addr[23:1], dl_data};
      else if ((dl_wr && same) || flush_go) pend_v <= 1'b0;
      flush_req <= dl_end || (flush_req && !flush_go);
      if ((dl_wr && full) || drop || (push && full && !pop)) dl_overrun <= 1'b1;
    end
  // SYNC adopts the controller's ack phase so the first request after reset is never spurious
  always_comb begin
    state_n = state;
    req_n = port.req;
    load = 1'b0;
    pop = 1'b0;
    case (state)
      SYNC: begin
        req_n = port.ack;
        state_n = IDLE;
      end
      IDLE: if (!empty) begin
        load = 1'b1;
        req_n = !port.req;
        state_n = BUSY;
      end
      BUSY: if (port.ack == port.req) begin
        pop = 1'b1;
        state_n = IDLE;
      end
      default: state_n = SYNC;
    endcase
  end
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      state <= SYNC;
      port.req <= 1'b0;
      port.a <= '0;
      port.ds <= '0;
      port.d <= '0;
    end else begin
      state <= state_n;
      port.req <= req_n;
      if (load) {port.a, port.ds, port.d} <= head;
    end
endmodule

// File: tb/tb_sdram_dl_writer.sv
// tb_sdram_dl_writer: scoreboard bench; a controller model acks requests and checks each write against queued expectations
module tb_sdram_dl_writer;
  import sdram_pkg::*;
  logic clk = 1'b0;
  logic init_n = 1'b0;
  logic dl_wr = 1'b0;
  logic [23:0] dl_addr = '0;
  logic [7:0] dl_data = '0;
  logic dl_end = 1'b0;
  logic dl_wait, dl_idle, dl_overrun;
  sdram_dl_writer_if pif();
  int checks = 0;
  int errors = 0;
  int ack_delay = 2;
  logic busy = 1'b0;
  sdram_wr_t q[$];

  sdram_dl_writer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .init_n(init_n), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_end(dl_end), .dl_wait(dl_wait), .dl_idle(dl_idle), .dl_overrun(dl_overrun), .port(pif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  function automatic logic [15:0] lane_mask(input logic [1:0] ds);
    return {{8{ds[1]}}, {8{ds[0]}}};
  endfunction

  task automatic expect_wr(input logic [23:1] a, input logic [1:0] ds, input logic [15:0] d);
    sdram_wr_t e;
    e.a = a;
    e.ds = ds;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    dl_addr = a;
    dl_data = d;
    dl_wr = 1'b1;
    @(negedge clk);
    dl_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string n);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dl_idle) begin
        ok = 1'b1;
        break;
      end
    end
    chk({n, "_idle"}, ok, 1'b1);
    chk({n, "_drained"}, q.size(), 0);
  endtask

  task automatic wait_not_full(input int budget);
    int i = 0;
    while (dl_wait && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (dl_wait) chk("wait_timeout", dl_wait, 1'b0);
  endtask

  // controller model: captures each new request, holds ack for ack_delay cycles, verifies stability meanwhile
  initial begin
    sdram_wr_t cur, e;
    int cnt = 0;
    pif.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!init_n) busy = 1'b0;
      else if (!busy && pif.req != pif.ack) begin
        cur = {pif.a, pif.ds, pif.d};
        busy = 1'b1;
        cnt = 0;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual a=%0h ds=%0b d=%0h required none", cur.a, cur.ds, cur.d);
        end else begin
          e = q.pop_front();
          chk("wr_a", cur.a, e.a);
          chk("wr_ds", cur.ds, e.ds);
          chk("wr_d", cur.d & lane_mask(e.ds), e.d & lane_mask(e.ds));
        end
      end else if (busy) begin
        chk("busy_stable", {pif.a, pif.ds, pif.d}, cur);
        cnt++;
        if (cnt >= ack_delay) begin
          pif.ack = pif.req;
          busy = 1'b0;
        end
      end
    end
  end

  initial begin
    logic r0;
    #1;
    chk("rst_req", pif.req, 1'b0);
    chk("rst_wait", dl_wait, 1'b0);
    chk("rst_overrun", dl_overrun, 1'b0);
    chk("rst_ds", pif.ds, 2'b00);
    chk("rst_a", pif.a, 0);
    chk("rst_d", pif.d, 0);
    chk("rst_idle", dl_idle, 1'b0);
    chk("rst_we", pif.we, 1'b1);
    @(negedge clk);
    #2 init_n = 1'b1;
    @(negedge clk);
    chk("idle_after_sync", dl_idle, 1'b1);

    // merged even/odd pair and request latency
    expect_wr(23'h000008, DS_W, 16'hABCD);
    r0 = pif.req;
    wr(24'h000010, 8'hAB);
    wr(24'h000011, 8'hCD);
    chk("req_not_yet", pif.req, r0);
    @(negedge clk);
    chk("req_toggled", pif.req, !r0);
    wait_idle(50, "merge");

    expect_wr(23'h000002, DS_LO, 16'h005A);
    wr(24'h000005, 8'h5A);
    wait_idle(50, "odd");

    expect_wr(23'h000010, DS_HI, 16'h1100);
    expect_wr(23'h000020, DS_HI, 16'h2200);
    wr(24'h000020, 8'h11);
    wr(24'h000040, 8'h22);
    dl_end = 1'b1;
    @(negedge clk);
    dl_end = 1'b0;
    wait_idle(50, "flush");

    // stalled controller: loader honours dl_wait
    ack_delay = 20;
    for (int i = 0; i < 10; i++) expect_wr(23'h000080 + 23'(i), DS_LO, {8'h00, 8'h30 + 8'(i)});
    for (int i = 0; i < 4; i++) wr(24'h000101 + 24'(2 * i), 8'h30 + 8'(i));
    chk("wait_full", dl_wait, 1'b1);
    for (int i = 4; i < 10; i++) begin
      wait_not_full(100);
      wr(24'h000101 + 24'(2 * i), 8'h30 + 8'(i));
    end
    wait_idle(400, "stall");
    chk("no_overrun", dl_overrun, 1'b0);

    // forced write while full is dropped and sticks the overrun flag
    for (int i = 0; i < 4; i++) expect_wr(23'h000100 + 23'(i), DS_LO, {8'h00, 8'h60 + 8'(i)});
    for (int i = 0; i < 4; i++) wr(24'h000201 + 24'(2 * i), 8'h60 + 8'(i));
    chk("wait_full2", dl_wait, 1'b1);
    wr(24'h0002F1, 8'hEE);
    chk("overrun_set", dl_overrun, 1'b1);
    wait_idle(400, "overrun");
    chk("overrun_sticky", dl_overrun, 1'b1);
    ack_delay = 2;
    init_n = 1'b0;
    #1;
    chk("overrun_cleared", dl_overrun, 1'b0);
    chk("req_reset", pif.req, 1'b0);

    // ack high at reset release: SYNC realigns req without a write
    pif.ack = 1'b1;
    @(negedge clk);
    #2 init_n = 1'b1;
    @(negedge clk);
    chk("sync_req", pif.req, 1'b1);
    @(negedge clk);
    chk("sync_idle", dl_idle, 1'b1);
    expect_wr(23'h000030, DS_LO, 16'h0077);
    wr(24'h000061, 8'h77);
    chk("sync_req_hold", pif.req, 1'b1);
    @(negedge clk);
    chk("sync_first_toggle", pif.req, 1'b0);
    wait_idle(50, "sync");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
